// File: rtl/bert_tx_config_sequencer.sv
// BERT TX config sequencer: applies register-block config updates to one GTX
// transmitter channel. Fast analog/pattern fields pass straight through; rate
// changes run the TXRATE/TXRATEDONE handshake; clock-source changes and
// software reset requests run a timed GTTXRESET/TXRESETDONE sequence.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | no sequence running; consumes the pending config if present
// RST_ASSERT | GTTXRESET held high for RESET_CYCLES, TXSYSCLKSEL applied here
// RST_WAIT   | GTTXRESET released, waiting for TXRESETDONE (bounded)
// RATE_WAIT  | TXRATE applied, waiting for a TXRATEDONE pulse (bounded)
module bert_tx_config_sequencer #(
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] config_in,
    input  logic        config_updated,
    input  logic        tx_ratedone,
    input  logic        tx_resetdone,
    output logic [2:0]  tx_prbssel,
    output logic        tx_polarity,
    output logic        tx_inhibit,
    output logic [2:0]  tx_rate,
    output logic [1:0]  tx_sysclksel,
    output logic        gttxreset,
    output logic [3:0]  tx_diffctrl,
    output logic [4:0]  tx_postcursor,
    output logic [4:0]  tx_precursor,
    output logic        busy,
    output logic        timeout
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [4:0]       PRE_MAX  = 5'h14;

    typedef struct packed {
        logic [2:0] prbsmode;
        logic       invert;
        logic       enable;
        logic [2:0] clkdiv;
        logic       clk_from_qpll;
        logic       tx_reset;
        logic [3:0] swing;
        logic [4:0] postcursor;
        logic [4:0] precursor;
    } bert_txconfig_t;

    typedef enum logic [1:0] {IDLE, RST_ASSERT, RST_WAIT, RATE_WAIT} state_t;

    state_t           state, state_nx;
    bert_txconfig_t   cur, cur_nx, pend, pend_nx;
    logic             pend_valid, pend_valid_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [2:0] tx_prbssel_nx, tx_rate_nx;
    logic       tx_polarity_nx, tx_inhibit_nx, gttxreset_nx, busy_nx, timeout_nx;
    logic [1:0] tx_sysclksel_nx;
    logic [3:0] tx_diffctrl_nx;
    logic [4:0] tx_postcursor_nx, tx_precursor_nx;

    logic rate_done_ok, rst_expired, rate_expired, need_reset;

    // A TXRATEDONE in the first RATE_WAIT cycle belongs to no request of ours.
    assign rate_done_ok = (state == RATE_WAIT) && tx_ratedone && (cnt != '0);
    assign rst_expired  = (state == RST_WAIT) && !tx_resetdone && (cnt == TO_LAST);
    assign rate_expired = (state == RATE_WAIT) && !rate_done_ok && (cnt == TO_LAST);
    assign need_reset   = pend.tx_reset || (pend.clk_from_qpll != cur.clk_from_qpll);

    // State and datapath registers; reset restarts the power-up reset sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RST_ASSERT;
            cnt           <= '0;
            cur           <= '0;
            pend          <= '0;
            pend_valid    <= 1'b0;
            tx_prbssel    <= 3'd0;
            tx_polarity   <= 1'b0;
            tx_inhibit    <= 1'b1;
            tx_rate       <= 3'd0;
            tx_sysclksel  <= 2'b00;
            gttxreset     <= 1'b1;
            tx_diffctrl   <= 4'd0;
            tx_postcursor <= 5'd0;
            tx_precursor  <= 5'd0;
            busy          <= 1'b1;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            cur           <= cur_nx;
            pend          <= pend_nx;
            pend_valid    <= pend_valid_nx;
            tx_prbssel    <= tx_prbssel_nx;
            tx_polarity   <= tx_polarity_nx;
            tx_inhibit    <= tx_inhibit_nx;
            tx_rate       <= tx_rate_nx;
            tx_sysclksel  <= tx_sysclksel_nx;
            gttxreset     <= gttxreset_nx;
            tx_diffctrl   <= tx_diffctrl_nx;
            tx_postcursor <= tx_postcursor_nx;
            tx_precursor  <= tx_precursor_nx;
            busy          <= busy_nx;
            timeout       <= timeout_nx;
        end
    end

    // Next-state selection; a reset sequence outranks a plain rate change.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    if (need_reset)                     state_nx = RST_ASSERT;
                    else if (pend.clkdiv != cur.clkdiv) state_nx = RATE_WAIT;
                end
            end
            RST_ASSERT: begin
                if (cnt == RST_LAST) state_nx = RST_WAIT;
            end
            RST_WAIT: begin
                if (tx_resetdone)     state_nx = (cur.clkdiv != tx_rate) ? RATE_WAIT : IDLE;
                else if (rst_expired) state_nx = IDLE;
            end
            RATE_WAIT: begin
                if (rate_done_ok || rate_expired) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the datapath and the registered GTX-facing outputs.
    always_comb begin
        cnt_nx           = cnt;
        cur_nx           = cur;
        pend_nx          = pend;
        pend_valid_nx    = pend_valid;
        tx_prbssel_nx    = tx_prbssel;
        tx_polarity_nx   = tx_polarity;
        tx_inhibit_nx    = tx_inhibit;
        tx_rate_nx       = tx_rate;
        tx_sysclksel_nx  = tx_sysclksel;
        gttxreset_nx     = gttxreset;
        tx_diffctrl_nx   = tx_diffctrl;
        tx_postcursor_nx = tx_postcursor;
        tx_precursor_nx  = tx_precursor;
        timeout_nx       = timeout;

        if (state == IDLE) begin
            if (pend_valid) begin
                cur_nx           = pend;
                pend_valid_nx    = 1'b0;
                tx_prbssel_nx    = pend.prbsmode;
                tx_polarity_nx   = pend.invert;
                tx_inhibit_nx    = !pend.enable;
                tx_diffctrl_nx   = pend.swing;
                tx_postcursor_nx = pend.postcursor;
                tx_precursor_nx  = (pend.precursor > PRE_MAX) ? PRE_MAX : pend.precursor;
            end
        end else begin
            cnt_nx = cnt + 1'b1;
        end

        if (state_nx != state) begin
            cnt_nx = '0;
            case (state_nx)
                RST_ASSERT: begin
                    gttxreset_nx    = 1'b1;
                    tx_sysclksel_nx = cur_nx.clk_from_qpll ? 2'b11 : 2'b00;
                end
                RST_WAIT:  gttxreset_nx = 1'b0;
                RATE_WAIT: tx_rate_nx   = cur_nx.clkdiv;
                default: ;
            endcase
        end

        // Single-depth pending slot: the latest strobe always wins.
        if (config_updated) begin
            pend_nx       = config_in;
            pend_valid_nx = 1'b1;
            timeout_nx    = 1'b0;
        end

        if (rst_expired || rate_expired) timeout_nx = 1'b1;

        busy_nx = (state_nx != IDLE) || pend_valid_nx;
    end

endmodule

// File: tb/tb_bert_tx_config_sequencer.sv
// Directed bench for bert_tx_config_sequencer: a table of fast-field updates
// plus hand-written sequences for reset, rate, clock-switch and rst corners.
module tb_bert_tx_config_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] config_in;
    logic        config_updated;
    logic        tx_ratedone;
    logic        tx_resetdone;
    logic [2:0]  tx_prbssel;
    logic        tx_polarity;
    logic        tx_inhibit;
    logic [2:0]  tx_rate;
    logic [1:0]  tx_sysclksel;
    logic        gttxreset;
    logic [3:0]  tx_diffctrl;
    logic [4:0]  tx_postcursor;
    logic [4:0]  tx_precursor;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bert_tx_config_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .config_in      (config_in),
        .config_updated (config_updated),
        .tx_ratedone    (tx_ratedone),
        .tx_resetdone   (tx_resetdone),
        .tx_prbssel     (tx_prbssel),
        .tx_polarity    (tx_polarity),
        .tx_inhibit     (tx_inhibit),
        .tx_rate        (tx_rate),
        .tx_sysclksel   (tx_sysclksel),
        .gttxreset      (gttxreset),
        .tx_diffctrl    (tx_diffctrl),
        .tx_postcursor  (tx_postcursor),
        .tx_precursor   (tx_precursor),
        .busy           (busy),
        .timeout        (timeout)
    );

    typedef struct {
        logic [23:0] cfg;
        logic [3:0]  diff;
        logic [4:0]  post;
        logic [4:0]  pre;
        logic [2:0]  prbs;
        logic        pol;
        logic        inh;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [23:0] mk(input logic [2:0] prbs, input logic inv, input logic en,
                                       input logic [2:0] div, input logic qpll, input logic trst,
                                       input logic [3:0] sw, input logic [4:0] post,
                                       input logic [4:0] pre);
        return {prbs, inv, en, div, qpll, trst, sw, post, pre};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // GTX reset model: TXRESETDONE drops while GTTXRESET is high and rises
    // five cycles after GTTXRESET is released.
    initial begin
        int rd_cnt;
        rd_cnt       = 0;
        tx_resetdone = 1'b0;
        forever begin
            step();
            if (gttxreset !== 1'b0) begin
                tx_resetdone = 1'b0;
                rd_cnt       = 0;
            end else if (!tx_resetdone) begin
                rd_cnt++;
                if (rd_cnt == 5) tx_resetdone = 1'b1;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic       flag;
        logic [3:0] prev_diff;

        vecs[0] = '{mk(3'd4, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd9,  5'h0c, 5'h1f), 4'd9,  5'h0c, 5'h14, 3'd4, 1'b0, 1'b0};
        vecs[1] = '{mk(3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'hf,  5'h1f, 5'h14), 4'hf,  5'h1f, 5'h14, 3'd2, 1'b1, 1'b1};
        vecs[2] = '{mk(3'd7, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0,  5'h00, 5'h15), 4'd0,  5'h00, 5'h14, 3'd7, 1'b0, 1'b0};
        vecs[3] = '{mk(3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 4'd5,  5'h03, 5'h13), 4'd5,  5'h03, 5'h13, 3'd0, 1'b1, 1'b0};

        rst            = 1'b1;
        config_in      = '0;
        config_updated = 1'b0;
        tx_ratedone    = 1'b0;

        // Power-up reset sequence
        repeat (3) step();
        chk("rst_gttxreset", gttxreset, 1);
        chk("rst_busy", busy, 1);
        chk("rst_inhibit", tx_inhibit, 1);
        chk("rst_timeout", timeout, 0);
        chk("rst_sysclksel", tx_sysclksel, 0);
        rst = 1'b0;
        n = 0;
        while (gttxreset === 1'b1 && n < 100) begin n++; step(); end
        chk("pwrup_gttxreset_len", n, 16);
        repeat (4) step();
        chk("pwrup_busy_before_done", busy, 1);
        step();
        chk("pwrup_busy_after_done", busy, 0);
        chk("pwrup_inhibit", tx_inhibit, 1);
        chk("pwrup_timeout", timeout, 0);

        // Fast-field updates from the table
        prev_diff = 4'd0;
        for (int i = 0; i < 4; i++) begin
            config_in      = vecs[i].cfg;
            config_updated = 1'b1;
            step();
            config_updated = 1'b0;
            chk("fast_busy_pending", busy, 1);
            chk("fast_diff_hold", tx_diffctrl, prev_diff);
            step();
            chk("fast_diffctrl", tx_diffctrl, vecs[i].diff);
            chk("fast_postcursor", tx_postcursor, vecs[i].post);
            chk("fast_precursor", tx_precursor, vecs[i].pre);
            chk("fast_prbssel", tx_prbssel, vecs[i].prbs);
            chk("fast_polarity", tx_polarity, vecs[i].pol);
            chk("fast_inhibit", tx_inhibit, vecs[i].inh);
            chk("fast_busy_clear", busy, 0);
            chk("fast_gttxreset", gttxreset, 0);
            chk("fast_rate", tx_rate, 0);
            prev_diff = vecs[i].diff;
        end

        // Rate 0 -> 1
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 4'd9, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        step();
        chk("rate1_txrate", tx_rate, 1);
        chk("rate1_busy", busy, 1);
        step();
        tx_ratedone = 1'b1;
        step();
        tx_ratedone = 1'b0;
        chk("rate1_done_busy", busy, 0);

        // Rate 1 -> 3 with ratedone 10 cycles after TXRATE changes
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 4'd9, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        chk("rate3_busy_pending", busy, 1);
        step();
        chk("rate3_txrate", tx_rate, 3);
        repeat (9) step();
        chk("rate3_busy_waiting", busy, 1);
        tx_ratedone = 1'b1;
        step();
        tx_ratedone = 1'b0;
        chk("rate3_done_busy", busy, 0);
        chk("rate3_txrate_kept", tx_rate, 3);
        chk("rate3_timeout", timeout, 0);

        // Rate 3 -> 5, ratedone only in the entry cycle, then timeout
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 4'd9, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        step();
        chk("rate5_txrate", tx_rate, 5);
        tx_ratedone = 1'b1;
        step();
        tx_ratedone = 1'b0;
        chk("entry_ratedone_ignored", busy, 1);
        n = 0;
        while (timeout !== 1'b1 && n < 70000) begin n++; step(); end
        chk("rate_timeout_set", timeout, 1);
        chk("rate_timeout_len_ok", (n >= 65530 && n <= 65540), 1);
        chk("rate_timeout_busy", busy, 0);
        chk("rate_timeout_txrate_kept", tx_rate, 5);

        // Clock switch CPLL -> QPLL together with rate 5 -> 2
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 4'd9, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        chk("strobe_clears_timeout", timeout, 0);
        chk("sysclk_before_reset", tx_sysclksel, 0);
        chk("gttxreset_before_reset", gttxreset, 0);
        step();
        chk("sw_gttxreset_rise", gttxreset, 1);
        chk("sw_sysclksel", tx_sysclksel, 3);
        n    = 0;
        flag = 1'b0;
        while (gttxreset === 1'b1 && n < 100) begin
            if (tx_sysclksel !== 2'b11 || busy !== 1'b1) flag = 1'b1;
            n++;
            step();
        end
        chk("sw_gttxreset_len", n, 16);
        chk("sw_during_reset_bad", flag, 0);
        n    = 0;
        flag = 1'b0;
        while (tx_rate !== 3'd2 && n < 100) begin
            if (busy !== 1'b1) flag = 1'b1;
            n++;
            step();
        end
        chk("sw_txrate", tx_rate, 2);
        chk("sw_busy_dropped", flag, 0);
        repeat (3) step();
        chk("sw_busy_rate_wait", busy, 1);
        tx_ratedone = 1'b1;
        step();
        tx_ratedone = 1'b0;
        chk("sw_done_busy", busy, 0);
        chk("sw_sysclksel_kept", tx_sysclksel, 3);

        // Two updates while in RST_WAIT: only the last one is applied
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 4'd1, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        step();
        chk("upd_reset_diffctrl", tx_diffctrl, 1);
        chk("upd_reset_gttxreset", gttxreset, 1);
        n = 0;
        while (gttxreset === 1'b1 && n < 100) begin n++; step(); end
        chk("upd_reset_len", n, 16);
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 4'd3, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 4'd7, 5'h0c, 5'h1f);
        step();
        config_updated = 1'b0;
        chk("upd_busy_in_wait", busy, 1);
        chk("upd_diff_not_early", tx_diffctrl, 1);
        n    = 0;
        flag = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (tx_diffctrl === 4'd3) flag = 1'b1;
            n++;
            step();
        end
        chk("upd_final_diffctrl", tx_diffctrl, 7);
        chk("upd_swing3_driven", flag, 0);
        chk("upd_gttxreset_low", gttxreset, 0);

        // rst asserted in RATE_WAIT with another update pending
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 4'ha, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        step();
        chk("mid_txrate", tx_rate, 6);
        chk("mid_diffctrl", tx_diffctrl, 4'ha);
        config_in = mk(3'd4, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 4'hb, 5'h0c, 5'h1f);
        config_updated = 1'b1;
        step();
        config_updated = 1'b0;
        rst = 1'b1;
        step();
        chk("mid_rst_prbssel", tx_prbssel, 0);
        chk("mid_rst_polarity", tx_polarity, 0);
        chk("mid_rst_inhibit", tx_inhibit, 1);
        chk("mid_rst_txrate", tx_rate, 0);
        chk("mid_rst_sysclksel", tx_sysclksel, 0);
        chk("mid_rst_gttxreset", gttxreset, 1);
        chk("mid_rst_diffctrl", tx_diffctrl, 0);
        chk("mid_rst_postcursor", tx_postcursor, 0);
        chk("mid_rst_precursor", tx_precursor, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_timeout", timeout, 0);
        rst = 1'b0;
        n = 0;
        while (gttxreset === 1'b1 && n < 100) begin n++; step(); end
        chk("mid_rst_seq_len", n, 16);
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; step(); end
        chk("mid_rst_busy_done", busy, 0);
        repeat (2) step();
        chk("mid_rst_pend_discarded", tx_diffctrl, 0);
        chk("mid_rst_rate_after", tx_rate, 0);
        chk("mid_rst_inhibit_after", tx_inhibit, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
